// File: rtl/four_bit_enable_counter.sv
// Up-counter with synchronous count-enable and cascade carry.
// Wraps from all-ones to zero; carry flags the edge that will wrap.
module four_bit_enable_counter #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [WIDTH-1:0] count,
    output logic             carry
);

    localparam logic [WIDTH-1:0] COUNT_MAX = '1;
    localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

    logic en_p0;

    // An X or Z enable must never advance the counter, so only a solid 1 counts.
    assign en_p0 = (enable === 1'b1);

    // Stage p0 -> count register
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (en_p0) begin
            count <= count + COUNT_ONE;
        end
    end

    assign carry = en_p0 & ~reset & (count == COUNT_MAX);

endmodule

// File: tb/tb_four_bit_enable_counter.sv
// Directed and randomized check of four_bit_enable_counter (WIDTH=4 and WIDTH=2)
// against a modulo-arithmetic reference model.
module tb_four_bit_enable_counter;

    logic       clk;
    logic       reset;
    logic       enable;
    logic [3:0] count4;
    logic       carry4;
    logic [1:0] count2;
    logic       carry2;

    int  compared   = 0;
    int  mismatched = 0;
    int  m4         = 0;
    int  m2         = 0;
    bit  valid      = 1'b0;

    four_bit_enable_counter #(.WIDTH(4)) dut4 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .count  (count4),
        .carry  (carry4)
    );

    four_bit_enable_counter #(.WIDTH(2)) dut2 (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .count  (count2),
        .carry  (carry2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+2: drive inputs, check pre-edge outputs, advance one edge.
    task automatic cyc(input logic r, input logic e);
        logic exp_c4;
        logic exp_c2;
        reset  = r;
        enable = e;
        #1;
        exp_c4 = (e === 1'b1) && !r && (m4 == 15);
        exp_c2 = (e === 1'b1) && !r && (m2 == 3);
        if (valid || r) begin
            check("carry4", 32'(carry4), 32'(exp_c4));
            check("carry2", 32'(carry2), 32'(exp_c2));
        end
        if (valid) begin
            check("count4_between_edges", 32'(count4), 32'(m4));
        end
        @(posedge clk);
        if (r) begin
            m4    = 0;
            m2    = 0;
            valid = 1'b1;
        end else if (e === 1'b1) begin
            m4 = (m4 + 1) % 16;
            m2 = (m2 + 1) % 4;
        end
        #2;
        if (valid) begin
            check("count4", 32'(count4), 32'(m4));
            check("count2", 32'(count2), 32'(m2));
        end
    endtask

    initial begin
        reset  = 1'b1;
        enable = 1'bx;
        @(posedge clk);
        #2;

        // 1: reset with enable unknown
        cyc(1'b1, 1'bx);
        cyc(1'b1, 1'bx);
        check("reset_count4", 32'(count4), 32'd0);
        check("reset_carry4", 32'(carry4), 32'd0);

        // 2: one enabled edge then hold
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        check("hold_at_one", 32'(count4), 32'd1);

        // 3: isolated single-cycle pulses
        cyc(1'b1, 1'b0);
        cyc(1'b0, 1'b1);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b1);
        check("two_pulses", 32'(count4), 32'd2);

        // 4: full wrap of the 4-bit counter
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b1);
        check("wrap_to_zero", 32'(count4), 32'd0);

        // 5: reset wins over enable mid-count
        for (int i = 0; i < 9; i++) cyc(1'b0, 1'b1);
        check("reached_nine", 32'(count4), 32'd9);
        cyc(1'b1, 1'b1);
        check("reset_mid_count", 32'(count4), 32'd0);
        cyc(1'b0, 1'b1);
        check("resume_from_zero", 32'(count4), 32'd1);

        // 6: 2-bit instance wrap sequence
        cyc(1'b1, 1'b0);
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b1);
        check("w2_after_wrap", 32'(count2), 32'd1);

        // Random enable (including X/Z) with occasional reset
        for (int i = 0; i < 400; i++) begin
            int   sel;
            logic e;
            logic r;
            sel = $urandom_range(0, 7);
            case (sel)
                0:       e = 1'bx;
                1:       e = 1'bz;
                2, 3:    e = 1'b0;
                default: e = 1'b1;
            endcase
            r = ($urandom_range(0, 19) == 0);
            cyc(r, e);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
